// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS instruction fetch unit.
package mips_pkg;

  localparam int unsigned INST_W = 32;
  localparam logic [INST_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One decoded-ready fetch result: the word and the address it came from.
  typedef struct packed {
    logic [INST_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } t_fetch_entry;

  // Instruction addresses are always word aligned.
  function automatic logic [INST_W-1:0] word_align(input logic [INST_W-1:0] addr);
    return {addr[INST_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/mips_fifo.sv
// Synchronous FIFO with flush; storage is registered so rdata reflects the head entry.
module mips_fifo
  import mips_pkg::*;
#(
  parameter int unsigned Width = INST_W,
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [CntW-1:0]  count
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(Depth));
  assign count = count_q;
  assign rdata = mem_q[rptr_q];

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = push & ~flush & (~full | pop);
  assign do_pop  = pop & ~empty & ~flush;

  // Pointer and occupancy tracking; flush empties the FIFO in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/mips_fetch.sv
// Instruction fetch: issues word requests, tags in-order responses with their PC,
// queues them for decode, and discards responses made stale by a redirect.
module mips_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int unsigned CntW = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned EntW = $bits(t_fetch_entry);

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] drop_q, drop_d;
  logic [CntW:0]   occupancy;
  logic            req_hs, dropping, rsp_keep;
  logic            iq_pop, iq_empty, iq_full;
  logic [CntW-1:0] iq_count;
  logic [31:0]     pcq_rdata;
  logic            pcq_empty, pcq_full;
  logic [CntW-1:0] pcq_count;
  t_fetch_entry    iq_wdata, iq_rdata;
  logic            unused_status;

  assign unused_status = ^{pcq_empty, pcq_full, pcq_count, iq_full};

  // Everything in flight (including responses still to be dropped) plus queued
  // entries must fit the queue, so every response always has room. A pop this
  // cycle frees a slot, which keeps one fetch per cycle at full throughput.
  assign occupancy = {1'b0, outstanding_q} + {1'b0, iq_count} - (CntW + 1)'(iq_pop);

  assign imem_req_valid = ~rst & ~redirect_valid & (occupancy < (CntW + 1)'(QUEUE_DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_hs         = imem_req_valid & imem_req_ready;

  assign dropping = (drop_q != '0);
  assign rsp_keep = imem_rsp_valid & ~dropping & ~redirect_valid;

  assign inst_valid = ~iq_empty & ~redirect_valid;
  assign iq_pop     = inst_valid & inst_ready;
  assign inst_pc    = iq_rdata.pc;
  assign inst_data  = iq_rdata.inst;

  assign iq_wdata.pc   = pcq_rdata;
  assign iq_wdata.inst = imem_rsp_data;

  // PC of each accepted request, waiting for its response.
  mips_fifo #(
    .Width (32),
    .Depth (QUEUE_DEPTH)
  ) u_pc_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (req_hs),
    .wdata (imem_req_addr),
    .pop   (rsp_keep),
    .rdata (pcq_rdata),
    .empty (pcq_empty),
    .full  (pcq_full),
    .count (pcq_count)
  );

  // Tagged instructions waiting for decode.
  mips_fifo #(
    .Width (EntW),
    .Depth (QUEUE_DEPTH)
  ) u_inst_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (rsp_keep),
    .wdata (iq_wdata),
    .pop   (iq_pop),
    .rdata (iq_rdata),
    .empty (iq_empty),
    .full  (iq_full),
    .count (iq_count)
  );

  // Next fetch address, in-flight count and stale-response count.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;

    if (redirect_valid) begin
      fetch_pc_d = word_align(redirect_pc);
    end else if (req_hs) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    unique case ({req_hs, imem_rsp_valid})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase

    // After a redirect every request still in flight belongs to the old path.
    if (redirect_valid) begin
      drop_d = outstanding_d;
    end else if (dropping && imem_rsp_valid) begin
      drop_d = drop_q - 1'b1;
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

endmodule
